// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device using the host request-to-send
// sequence: inhibit the clock, pull data low (start bit), release the clock,
// then drive data bits, odd parity and stop on the device's falling clock
// edges, and finally sample the device ACK.
//
// Parameters:
//   INHIBIT_CYCLES - clk cycles the PS/2 clock is held low before request-to-send
//   TIMEOUT_CYCLES - watchdog limit in clk cycles, counted from REQ
//
// Ports:
//   clk          in   system clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   tx_data      in   command byte
//   tx_valid     in   transmit request
//   tx_ready     out  idle and able to accept a byte
//   ps2_clk_in   in   PS/2 clock line level (asynchronous)
//   ps2_data_in  in   PS/2 data line level (asynchronous)
//   ps2_clk_oe   out  1 = pull PS/2 clock low (registered)
//   ps2_data_oe  out  1 = pull PS/2 data low (registered)
//   done         out  one-cycle completion pulse
//   ack_error    out  device did not ACK (valid with done, held until next byte)
//   timeout      out  watchdog abort (valid with done, held until next byte)
//
// Build option: define PS2_TX_TIMEOUT_EN to enable the watchdog; otherwise
// timeout is tied low and the frame waits indefinitely for the device.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_error,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_FINISH
    } state_t;

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_ONE  = IW'(1);

    state_t        state_q, state_d;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          data_meta_q, data_sync_q;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          ack_err_q, ack_err_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          fall;
    logic          accept;
    logic [9:0]    line_bits;

    assign fall      = clk_prev_q & ~clk_sync_q;
    assign accept    = tx_valid & (state_q == S_IDLE);
    // Frame as seen on the wire, indexed by the number of edges seen so far:
    // 0 = start bit, 1..8 = data LSB first, 9 = parity.
    assign line_bits = {parity_q, byte_q, 1'b0};

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_ONE  = WW'(1);

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q, timeout_d;
    logic          wd_active;
    logic          wd_expired;

    // The watchdog covers everything from REQ until FINISH; it is held at 0
    // elsewhere so REQ always starts counting from zero.
    assign wd_active  = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                        (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign wd_expired = wd_active && (wd_cnt_q == WD_LAST);
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            inh_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            ack_err_q   <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            byte_q      <= byte_d;
            parity_q    <= parity_d;
            inh_cnt_q   <= inh_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_err_q   <= ack_err_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_INHIBIT;
            S_INHIBIT:   if (inh_cnt_q == INH_LAST) state_d = S_REQ;
            S_REQ:       state_d = S_SHIFT;
            S_SHIFT:     if (fall && (bit_cnt_q == 4'd9)) state_d = S_ACK;
            S_ACK:       if (fall) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (clk_sync_q && data_sync_q) state_d = S_FINISH;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (wd_expired) state_d = S_FINISH;
`endif
    end

    // Datapath next values and registered line drivers. The drivers are
    // derived from the next state so each register already holds the level
    // belonging to the state it is entering.
    always_comb begin
        byte_d    = byte_q;
        parity_d  = parity_q;
        inh_cnt_d = '0;
        bit_cnt_d = bit_cnt_q;
        ack_err_d = ack_err_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    byte_d    = tx_data;
                    parity_d  = ~^tx_data;
                    bit_cnt_d = '0;
                    ack_err_d = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q != INH_LAST) inh_cnt_d = inh_cnt_q + INH_ONE;
            end
            S_SHIFT: begin
                if (fall) bit_cnt_d = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
            end
            S_ACK: begin
                if (fall) ack_err_d = data_sync_q;
            end
            default: ;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        timeout_d = timeout_q;
        wd_cnt_d  = wd_active ? wd_cnt_q + WD_ONE : '0;
        if (accept) timeout_d = 1'b0;
        if (wd_expired) begin
            ack_err_d = 1'b1;
            timeout_d = 1'b1;
            bit_cnt_d = '0;
        end
`endif

        case (state_d)
            S_INHIBIT: begin
                clk_oe_d  = 1'b1;
                // Start bit is asserted in the final inhibit cycle.
                data_oe_d = (inh_cnt_d == INH_LAST);
            end
            S_REQ:   data_oe_d = 1'b1;
            S_SHIFT: data_oe_d = ~line_bits[bit_cnt_d];
            default: ;
        endcase

        done_d = (state_d == S_FINISH);
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_error   = ack_err_q;

endmodule
